// File: rtl/ahb_pkg.sv
// AHB-Lite transfer encodings and the responder state type shared by the
// responder and the bridge-side lane decoder.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } resp_state_t;

endpackage

// File: rtl/ahb_lane_dec.sv
// Byte-lane enable decode from transfer size and low address bits; sizes
// above a word collapse to a full-word access.
module ahb_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] lanes
);

  always_comb begin
    lanes = 4'b1111;
    case (hsize)
      BYTE:    lanes = 4'b0001 << addr;
      HALF:    lanes = addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: word-organised memory behind a single-slave bus
// with programmable data-phase wait states and write-to-read forwarding.
module ahb_mem_responder
  import ahb_pkg::*;
#(
  parameter int AHB_DW      = 32,
  parameter int AHB_AW      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AHB_AW-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [AHB_DW-1:0] hwdata,
  output logic [AHB_DW-1:0] hrdata,
  output logic              hready
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_t       state;
  logic [3:0]        wait_cnt;
  logic [IDX_W-1:0]  idx_p1;
  logic [1:0]        boff_p1;
  logic [2:0]        size_p1;
  logic              write_p1;
  logic [3:0]        lanes_p1;
  logic [AHB_DW-1:0] mem [MEM_DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  idx_p0;
  logic              wr_commit;
  logic              rd_load;
  logic [IDX_W-1:0]  rd_idx;
  logic [AHB_DW-1:0] rd_word;
  logic              unused_ok;

  function automatic logic [AHB_DW-1:0] merge_lanes(input logic [AHB_DW-1:0] old_w,
                                                     input logic [AHB_DW-1:0] new_w,
                                                     input logic [3:0]        lanes);
    logic [AHB_DW-1:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign accept    = hready && htrans[1];
  assign idx_p0    = haddr[IDX_W+1:2];
  assign wr_commit = (state == ST_DATA) && write_p1;
  assign rd_load   = (accept && (WAIT_STATES == 0) && !hwrite) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd0) && !write_p1);
  assign rd_idx    = (state == ST_WAIT) ? idx_p1 : idx_p0;
  // A read entering its data phase on the edge that commits a write to the
  // same word must see the merged result, not the stale memory word.
  assign rd_word   = (wr_commit && (idx_p1 == rd_idx)) ?
                     merge_lanes(mem[idx_p1], hwdata, lanes_p1) : mem[rd_idx];
  assign unused_ok = ^{hburst, haddr[AHB_AW-1:IDX_W+2]};

  ahb_lane_dec u_lane_dec (
    .hsize (size_p1),
    .addr  (boff_p1),
    .lanes (lanes_p1)
  );

  // p0 -> p1: address-phase capture into data-phase registers
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p1   <= idx_p0;
      boff_p1  <= haddr[1:0];
      size_p1  <= hsize;
      write_p1 <= hwrite;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      hready   <= 1'b1;
      hrdata   <= '0;
    end else begin
      hrdata <= rd_load ? rd_word : '0;
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state  <= ST_DATA;
            hready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state  <= ST_DATA;
              hready <= 1'b1;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WS_RELOAD;
              hready   <= 1'b0;
            end
          end else begin
            state  <= ST_IDLE;
            hready <= 1'b1;
          end
        end
      endcase
    end
  end

  // p1 -> memory: write commit at the end of the final data-phase cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_commit) begin
      mem[idx_p1] <= merge_lanes(mem[idx_p1], hwdata, lanes_p1);
    end
  end

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Randomised and directed bench for ahb_mem_responder: a pipelined bus master
// drives one zero-wait and one three-wait instance against a byte-level memory model.
module tb_ahb_mem_responder;
  import ahb_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans0, htrans1;
  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1;
  int          sel = 0;

  always #5 clk = ~clk;

  assign htrans0 = (sel == 0) ? htrans : 2'b00;
  assign htrans1 = (sel == 1) ? htrans : 2'b00;

  ahb_mem_responder #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .haddr(haddr), .htrans(htrans0), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0)
  );

  ahb_mem_responder #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .haddr(haddr), .htrans(htrans1), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata1), .hready(hready1)
  );

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] mem_m [2][DEPTH];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] model_write(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [2:0] sz);
    int nb, off;
    logic [31:0] r;
    nb  = (sz >= 3'd2) ? 4 : (1 << sz);
    off = (int'(a % 32'd4) / nb) * nb;
    r   = old_w;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + nb) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic clear_models();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) mem_m[s][i] = '0;
  endtask

  task automatic push(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit chk, input logic [31:0] exp);
    xfer_t x;
    x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = wd; x.chk = chk; x.exp = exp;
    q.push_back(x);
  endtask

  // Plays the queue as a pipelined master; returns the number of bus cycles used.
  task automatic run(output int cycles);
    xfer_t       dp;
    bit          dp_vld;
    int          lows, budget, ws;
    logic        rdy;
    logic [31:0] rd;
    dp_vld = 0; lows = 0; budget = 0; cycles = 0;
    ws = (sel == 1) ? 3 : 0;
    while ((q.size() > 0 || dp_vld) && budget < 2000) begin
      @(negedge clk);
      rdy = (sel == 1) ? hready1 : hready0;
      rd  = (sel == 1) ? hrdata1 : hrdata0;
      hwdata = dp_vld ? dp.wdata : $urandom;
      hburst = 3'($urandom);
      if (q.size() > 0) begin
        haddr = q[0].addr; htrans = q[0].trans; hwrite = q[0].wr; hsize = q[0].size;
      end else begin
        haddr = $urandom; htrans = IDLE; hwrite = 1'($urandom); hsize = 3'($urandom);
      end
      if (!dp_vld) begin
        check("idle_hready", {31'b0, rdy}, 32'd1);
        check("idle_hrdata", rd, 32'd0);
      end else if (!rdy) begin
        lows++;
      end else begin
        check("wait_cycles", 32'(lows), 32'(ws));
        if (dp.wr) begin
          mem_m[sel][widx(dp.addr)] = model_write(mem_m[sel][widx(dp.addr)], dp.wdata, dp.addr, dp.size);
        end else begin
          check("rdata", rd, mem_m[sel][widx(dp.addr)]);
          if (dp.chk) check("rdata_const", rd, dp.exp);
        end
        dp_vld = 0; lows = 0;
      end
      if (rdy && q.size() > 0) begin
        if (q[0].trans[1]) begin
          dp = q.pop_front();
          dp_vld = 1;
        end else begin
          void'(q.pop_front());
        end
      end
      cycles++; budget++;
    end
    if (budget >= 2000) begin
      check("run_timeout", 32'(budget), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    clear_models();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hready0", {31'b0, hready0}, 32'd1);
    check("rst_hrdata0", hrdata0, 32'd0);
    check("rst_hready1", {31'b0, hready1}, 32'd1);
    check("rst_hrdata1", hrdata1, 32'd0);
    reset_n = 1'b1;

    // zero-wait instance: word write/read, partial writes, forwarding, bursts, aliasing
    sel = 0;
    push(NONSEQ, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0);
    push(NONSEQ, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    push(IDLE,   0, 3'd2, 32'h0,  32'h0, 0, 0);
    push(IDLE,   0, 3'd2, 32'h0,  32'h0, 0, 0);
    run(cyc);
    push(NONSEQ, 1, 3'd0, 32'h13, 32'hA5000000, 0, 0);
    push(NONSEQ, 1, 3'd1, 32'h10, 32'h00001234, 0, 0);
    push(NONSEQ, 0, 3'd2, 32'h10, 32'h0, 1, 32'hA5AD1234);
    run(cyc);
    push(NONSEQ, 1, 3'd2, 32'h20, 32'h11223344, 0, 0);
    push(NONSEQ, 0, 3'd2, 32'h20, 32'h0, 1, 32'h11223344);
    run(cyc);
    for (int i = 0; i < 4; i++)
      push(i == 0 ? NONSEQ : SEQ, 1, 3'd2, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i), 0, 0);
    run(cyc);
    check("incr4_wr_cycles", 32'(cyc), 32'd5);
    for (int i = 0; i < 4; i++)
      push(i == 0 ? NONSEQ : SEQ, 0, 3'd2, 32'h40 + 32'(4*i), 32'h0, 1, 32'hC0DE0000 + 32'(i));
    run(cyc);
    check("incr4_rd_cycles", 32'(cyc), 32'd5);
    push(NONSEQ, 1, 3'd2, 32'h400, 32'h5555AAAA, 0, 0);
    push(NONSEQ, 0, 3'd2, 32'h0, 32'h0, 1, 32'h5555AAAA);
    run(cyc);

    // three-wait instance: wait-state count, IDLE/BUSY gaps
    sel = 1;
    push(NONSEQ, 1, 3'd2, 32'h10, 32'h0BADCAFE, 0, 0);
    push(IDLE,   0, 3'd2, 32'h44, 32'h0, 0, 0);
    push(BUSY,   1, 3'd2, 32'h48, 32'h0, 0, 0);
    push(NONSEQ, 0, 3'd2, 32'h10, 32'h0, 1, 32'h0BADCAFE);
    run(cyc);
    push(NONSEQ, 1, 3'd2, 32'h30, 32'h77778888, 0, 0);
    push(NONSEQ, 0, 3'd2, 32'h30, 32'h0, 1, 32'h77778888);
    run(cyc);

    // reset in the middle of a waited write
    @(negedge clk);
    haddr = 32'h30; htrans = NONSEQ; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    htrans = IDLE; hwdata = 32'hCAFEF00D;
    check("wait_hready", {31'b0, hready1}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_hready", {31'b0, hready1}, 32'd1);
    check("async_rst_hrdata", hrdata1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_models();
    push(NONSEQ, 0, 3'd2, 32'h30, 32'h0, 1, 32'h0);
    run(cyc);

    // randomised traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int n = 0; n < 150; n++) begin
        logic [1:0]  tr;
        logic [31:0] a;
        int          pick;
        pick = $urandom_range(0, 9);
        tr = (pick == 0) ? IDLE : (pick == 1) ? BUSY : (pick < 6) ? NONSEQ : SEQ;
        a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) |
             (32'($urandom_range(0, 3)) << 10);
        push(tr, 1'($urandom), 3'($urandom_range(0, 3)), a, $urandom, 0, 0);
      end
      run(cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
AHB-Lite responder (slave) for the ahb_vif signal set. It answers master-driven transfers from the AHB agent or a DUT's upstream port.
- Single-slave bus, so no decode select.
- Backed by a word-organised memory with programmable wait states.
- Serves as the bus-side memory model in the ahb2apb environment and as a synthesizable target for loopback checks of the master driver.

Parameters:
AHB_DW, 32, data bus width in bits; only 32 supported.
AHB_AW, 32, address bus width in bits.
MEM_DEPTH, 256, memory size in AHB_DW-bit words; power of two.
WAIT_STATES, 0, hready-low cycles inserted in every data phase (0..15).

Ports:
clk  input  1  bus clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
haddr  input  AHB_AW  transfer address, address phase
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  input  1  1=write, 0=read
hsize  input  3  0=byte, 1=half, 2=word
hburst  input  3  burst type; accepted, not used for addressing
hwdata  input  AHB_DW  write data, data phase
hrdata  output  AHB_DW  read data, valid while hready=1 in a read data phase
hready  output  1  transfer-done / address-accept strobe

Behaviour:
- Reset (async assert, sync deassert on clk): hready=1, hrdata=0, state=ST_IDLE, wait counter=0, all memory words=0.
- Address phase accepted on a rising edge where hready=1 and htrans[1]=1 (NONSEQ/SEQ). Capture haddr, hwrite, hsize into the data-phase registers.
- IDLE and BUSY are never accepted; they create no data phase.
- Word index = haddr[log2(MEM_DEPTH)+1:2]. Higher address bits are ignored, so the index wraps modulo MEM_DEPTH.
- Byte lanes are decoded from the captured hsize and haddr[1:0]:
  - byte: one lane, selected by addr[1:0].
  - half: lanes {1,0} or {3,2}, selected by addr[1]; addr[0] ignored.
  - word, or hsize>2: all four lanes; addr[1:0] ignored.
- State machine (3 states):
  - ST_IDLE: no data phase pending; hready=1.
  - ST_WAIT: hready=0; counter decrements each cycle; move to ST_DATA when counter==0.
  - ST_DATA: final data-phase cycle; hready=1.
- Transitions on acceptance:
  - From ST_IDLE or ST_DATA with WAIT_STATES=0: go to ST_DATA.
  - From ST_IDLE or ST_DATA with WAIT_STATES>0: go to ST_WAIT, counter=WAIT_STATES-1.
  - ST_DATA with no acceptance: go to ST_IDLE.
- Pipelining: in ST_DATA the next address phase overlaps the current data phase. Back-to-back NONSEQ/SEQ with WAIT_STATES=0 gives one transfer per cycle.
- In ST_WAIT, address and control on the bus are ignored; the master must hold them.
- Write: hwdata is sampled on the edge that ends ST_DATA. Only the enabled lanes of the addressed word are updated.
- Read: hrdata is registered and loaded on the edge that enters ST_DATA, from the addressed word, with all 4 lanes returned. It is cleared to 0 on the edge leaving a read ST_DATA without a following read.
- Read-after-write forwarding: a read accepted on the same edge that completes a write to the same word index returns the merged word (new lanes from hwdata, other lanes from memory). Zero-wait back-to-back W->R to the same address must return the new data.
- Simultaneous write completion and new write acceptance: the completed write commits and the new one is captured, with no lost cycle.
- Reset mid-transfer: the pending write is discarded (no memory update), state=ST_IDLE, hready=1 immediately.

Decomposition:
- ahb_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - hsize_t enum (BYTE, HALF, WORD)
  - hburst_t enum (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16)
  - the resp_state_t enum (ST_IDLE, ST_WAIT, ST_DATA)
- One sub-module, ahb_lane_dec: combinational hsize + addr[1:0] -> 4-bit lane enable. It is reused later by the bridge's APB pstrb generation.

Test Plan:
- Reset then single word write 0x0000_0010 <- 0xDEADBEEF, then read 0x10, WAIT_STATES=0 -> hready never low; hrdata=0xDEADBEEF in the read data phase; hrdata=0 after.
- Byte write 0xA5 at 0x13, then half write 0x1234 at 0x10, over the prior word -> read 0x10 returns 0xA5AD1234.
- Zero-wait back-to-back write 0x20 <- 0x11223344 then read 0x20 on the next cycle -> hrdata=0x11223344 (forwarding); 4-beat INCR4 SEQ writes then reads complete in 4+1 cycles each.
- WAIT_STATES=3, read 0x10 -> hready low exactly 3 cycles, then high for 1 cycle with correct data; BUSY/IDLE in between produce no data phase.
- Address 0x0000_0400 with MEM_DEPTH=256 -> aliases word 0; write there and read 0x0 returns the same value.
- Assert reset_n during ST_WAIT of a write to 0x30 -> hready=1 asynchronously; a subsequent read of 0x30 returns 0.
